layer_train_sequencer: RTL

LAYER_TRAIN_SEQUENCER -- requirements
Module: layer_train_sequencer

---
 rtl/layer_train_sequencer_pkg.sv | 28 ++
 rtl/layer_train_sequencer_if.sv | 31 +++
 rtl/zero2one_abs_err_sum.sv | 20 ++
 rtl/layer_train_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/layer_train_sequencer_pkg.sv
// Shared definitions for the layer training sequencer: data encodings, FSM states and
// small arithmetic helpers.
package layer_train_sequencer_pkg;

  // 8-bit unsigned encoding of the range 0.0 .. 1.0.
  typedef logic [7:0]  zero2one_t;
  typedef logic [15:0] frac_t;

  typedef enum logic [2:0] {
    StIdle,
    StPresent,
    StCapture,
    StLearn,
    StNext,
    StDone
  } train_state_t;

  function automatic zero2one_t abs_diff(input zero2one_t a, input zero2one_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/layer_train_sequencer_if.sv
// Stimulus/response bundle between the training sequencer (master) and the layer (slave).
interface layer_train_sequencer_if
  import layer_train_sequencer_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned M = 29
);

  logic      layer_valid;
  logic      layer_learn;
  zero2one_t layer_in           [N];
  zero2one_t layer_expected_out [M];
  zero2one_t layer_out          [M];

  modport master (
    output layer_valid,
    output layer_learn,
    output layer_in,
    output layer_expected_out,
    input  layer_out
  );

  modport slave (
    input  layer_valid,
    input  layer_learn,
    input  layer_in,
    input  layer_expected_out,
    output layer_out
  );

endinterface

// File: rtl/zero2one_abs_err_sum.sv
// Combinational sum of absolute differences between two zero2one_t vectors, computed on
// the raw unsigned encodings.
module zero2one_abs_err_sum
  import layer_train_sequencer_pkg::*;
#(
  parameter int unsigned M = 29
) (
  input  zero2one_t   actual   [M],
  input  zero2one_t   expected [M],
  output logic [31:0] sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < M; i++) begin
      sum = sum + 32'(abs_diff(actual[i], expected[i]));
    end
  end

endmodule

// File: rtl/layer_train_sequencer.sv
// Replays a small sample memory through a trainable layer for a fixed number of epochs.
// Optional per-epoch error accumulation is enabled by defining TRAIN_ERR_ACC_EN.
module layer_train_sequencer
  import layer_train_sequencer_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned M      = 29,
  parameter int unsigned S      = 8,
  parameter int unsigned EPOCHS = 4,
  parameter int unsigned LAT    = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         wr_en,
  input  logic [$clog2(S)-1:0]         wr_addr,
  input  zero2one_t                    wr_in       [N],
  input  zero2one_t                    wr_expected [M],
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(EPOCHS+1)-1:0]  epoch_cnt,
  output logic [$clog2(S)-1:0]         sample_idx,
  output logic [31:0]                  epoch_error,
  layer_train_sequencer_if.master      layer
);

  localparam int unsigned IdxW = $clog2(S);
  localparam int unsigned EcW  = $clog2(EPOCHS + 1);

  localparam logic [IdxW-1:0] IdxLast   = IdxW'(S - 1);
  localparam logic [EcW-1:0]  EpochLast = EcW'(EPOCHS - 1);
  localparam logic [3:0]      LatLast   = 4'(LAT - 1);

  train_state_t    state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [EcW-1:0]  epoch_q, epoch_d;
  logic [3:0]      lat_q, lat_d;
  logic            kill;
  logic            drive;

  zero2one_t mem_in  [S][N];
  zero2one_t mem_exp [S][M];
  zero2one_t cur_in  [N];
  zero2one_t cur_exp [M];

  // Abort only means something once a run is in flight.
  assign kill = abort && (state_q != StIdle);

  // Sample memory survives reset and abort; it is only writable while idle.
  always_ff @(posedge clock) begin
    if (state_q == StIdle && wr_en) begin
      mem_in[wr_addr]  <= wr_in;
      mem_exp[wr_addr] <= wr_expected;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) cur_in[i] = mem_in[idx_q][i];
    for (int i = 0; i < M; i++) cur_exp[i] = mem_exp[idx_q][i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      epoch_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      epoch_q <= epoch_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:    if (start) state_d = StPresent;
        StPresent: if (lat_q == LatLast) state_d = StCapture;
        StCapture: state_d = StLearn;
        StLearn:   state_d = StNext;
        StNext: begin
          if (idx_q == IdxLast && epoch_q == EpochLast) state_d = StDone;
          else                                          state_d = StPresent;
        end
        StDone:    state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    idx_d   = idx_q;
    epoch_d = epoch_q;
    lat_d   = (state_q == StPresent) ? lat_q + 4'd1 : 4'd0;
    if (!kill) begin
      case (state_q)
        StIdle: begin
          if (start) begin
            idx_d   = '0;
            epoch_d = '0;
          end
        end
        StNext: begin
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            epoch_d = epoch_q + EcW'(1);
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy              = (state_q != StIdle);
    done              = (state_q == StDone);
    drive             = (state_q == StPresent) || (state_q == StCapture) || (state_q == StLearn);
    layer.layer_valid = drive;
    layer.layer_learn = (state_q == StLearn);
    for (int i = 0; i < N; i++) layer.layer_in[i] = drive ? cur_in[i] : '0;
    for (int i = 0; i < M; i++) layer.layer_expected_out[i] = drive ? cur_exp[i] : '0;
  end

  assign epoch_cnt  = epoch_q;
  assign sample_idx = idx_q;

`ifdef TRAIN_ERR_ACC_EN
  logic [31:0] acc_q, acc_d;
  logic [31:0] err_q, err_d;
  logic [31:0] err_sum;
  zero2one_t   out_s [M];

  always_comb begin
    for (int i = 0; i < M; i++) out_s[i] = layer.layer_out[i];
  end

  zero2one_abs_err_sum #(
    .M(M)
  ) u_err_sum (
    .actual   (out_s),
    .expected (cur_exp),
    .sum      (err_sum)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      err_q <= '0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  // epoch_error is only published at the end of a full epoch, so an abort leaves it alone.
  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    if (!kill) begin
      if (state_q == StIdle && start) begin
        acc_d = '0;
      end else if (state_q == StCapture) begin
        acc_d = sat_add32(acc_q, err_sum);
      end else if (state_q == StNext && idx_q == IdxLast) begin
        err_d = acc_q;
        acc_d = '0;
      end
    end
  end

  assign epoch_error = err_q;
`else
  logic unused_layer_out;

  always_comb begin
    unused_layer_out = 1'b0;
    for (int i = 0; i < M; i++) unused_layer_out = unused_layer_out ^ (^layer.layer_out[i]);
  end

  assign epoch_error = '0;
`endif

endmodule
